regdecode_stack: RTL and testbench
==================================

Name: regdecode_stack

Overview:
- Parametrised successor to the register-bank decoder.
- Holds the current play-area (PA) bank pointer and prepends it to NUM_PORTS lower register addresses in parallel, producing full register-file addresses for every operand port in the same cycle.
- Adds a hardware PA stack (push/pop) so subroutine-style code can switch banks and return without software save/restore.
- Adds sticky overflow and underflow error flags.
- Sits between the instruction decoder and the register file.

Parameters:
- PA_W, 2, width of the play-area (bank) pointer.
- LOW_W, 2, width of each lower register address field from the instruction.
- NUM_PORTS, 3, number of operand address channels decoded in parallel.
- STACK_DEPTH, 4, number of saved PA entries; must be at least 1.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth count.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- set_en  in  1  load set_pa into the current PA this cycle.
- set_pa  in  PA_W  new PA value.
- push  in  1  save the current PA onto the stack.
- pop  in  1  restore the current PA from the stack top.
- clr_flags  in  1  clear the sticky error flags.
- lower_reg_addr  in  NUM_PORTS*LOW_W  packed lower addresses; port i occupies [i*LOW_W +: LOW_W].
- reg_addr  out  NUM_PORTS*(PA_W+LOW_W)  packed full addresses; port i = {cur_pa, lower_i}.
- cur_pa  out  PA_W  current PA register.
- depth  out  DEPTH_W  number of valid stack entries.
- overflow  out  1  sticky; a push was attempted while the stack was full.
- underflow  out  1  sticky; a pop was attempted while the stack was empty.

Behaviour:
- Reset: when reset_n=0 at a rising edge, cur_pa=0, depth=0, overflow=0, underflow=0, and all stack entries=0. Reset overrides every other input, including mid-sequence push/pop.
- Address decode:
  - reg_addr is purely combinational from cur_pa and lower_reg_addr, with zero latency.
  - A PA change becomes visible on reg_addr in the cycle after the edge that commits it.
- Per-edge operation, evaluated in this priority order:
  1. push=1 and pop=1: the stack and depth are unchanged. If set_en=1, cur_pa<=set_pa; otherwise cur_pa is unchanged. No flag is set.
  2. push=1 only:
     - If depth<STACK_DEPTH: stack[depth]<=cur_pa and depth<=depth+1. cur_pa<=set_pa if set_en=1, else it is unchanged. push with set_en is the "call into new bank" operation.
     - If depth==STACK_DEPTH: the stack, depth and cur_pa are all unchanged (set_en is ignored) and overflow<=1.
  3. pop=1 only:
     - If depth>0: cur_pa<=stack[depth-1] and depth<=depth-1. set_en is ignored because pop wins.
     - If depth==0: cur_pa and depth are unchanged (set_en is ignored) and underflow<=1.
  4. set_en=1 only: cur_pa<=set_pa.
  5. No operation: all state holds.
- Flags:
  - overflow and underflow remain 1 until reset or clr_flags=1.
  - If clr_flags=1 coincides with a new error event in the same cycle, the flag is set, because the error wins.
- Stack entries at or above depth hold stale data and are never visible on any output.
- Width rules: no arithmetic is performed on cur_pa; depth never wraps and is saturated by the rules above.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with push=1 and set_en=1 → cur_pa=0, depth=0, both flags 0. With lower port0=2'b11, reg_addr port0 reads 4'b0011.
- Set and decode: set_en=1 with set_pa=2'b10 for 1 cycle → next cycle cur_pa=2. Lower addresses {1,2,3} give reg_addr ports {4'b1001, 4'b1010, 4'b1011}.
- Call/return: from cur_pa=1, push+set_en with set_pa=3 → cur_pa=3, depth=1. Then pop → cur_pa=1, depth=0. No flags are set.
- Overflow: perform 4 pushes (set_pa 1,2,3,0), then a 5th push with set_pa=2 → depth stays 4, cur_pa stays 0, overflow=1. Four subsequent pops return 3,2,1,0 in that order.
- Underflow and clear: pop at depth=0 → underflow=1, cur_pa unchanged. Then clr_flags=1 → underflow=0. Then pop and clr_flags together at depth=0 → underflow=1.
- Simultaneous: push+pop+set_en with set_pa=2 at depth=2 → depth stays 2, cur_pa=2, flags unchanged. Asserting reset_n=0 in the same cycle as a push → depth=0.

Source files
------------

// File: rtl/regdecode_stack.sv
// Play-area bank decoder with a hardware PA call stack and sticky error flags.
// Prepends the current bank pointer to every operand's lower register address.
module regdecode_stack #(
   parameter int PA_W        = 2,
   parameter int LOW_W       = 2,
   parameter int NUM_PORTS   = 3,
   parameter int STACK_DEPTH = 4,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            set_en,
   input  logic [PA_W-1:0]                 set_pa,
   input  logic                            push,
   input  logic                            pop,
   input  logic                            clr_flags,
   input  logic [NUM_PORTS*LOW_W-1:0]      lower_reg_addr,
   output logic [NUM_PORTS*(PA_W+LOW_W)-1:0] reg_addr,
   output logic [PA_W-1:0]                 cur_pa,
   output logic [DEPTH_W-1:0]              depth,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int                 PTR_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int                 ADDR_W     = PA_W + LOW_W;
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] ONE        = DEPTH_W'(1);

   logic [PA_W-1:0]    stack_q [STACK_DEPTH];
   logic [PA_W-1:0]    cur_pa_q, cur_pa_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               stack_we;
   logic [PTR_W-1:0]   wr_idx, rd_idx;
   logic               full, empty;

   assign full   = (depth_q == FULL_DEPTH);
   assign empty  = (depth_q == '0);
   assign wr_idx = PTR_W'(depth_q);
   assign rd_idx = PTR_W'(depth_q - ONE);

   // Priority: push+pop together, push, pop, plain set, idle.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      cur_pa_d    = cur_pa_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q & ~clr_flags;
      underflow_d = underflow_q & ~clr_flags;
      stack_we    = 1'b0;

      if (push && pop) begin
         if (set_en) cur_pa_d = set_pa;
      end else if (push) begin
         if (!full) begin
            stack_we = 1'b1;
            depth_d  = depth_q + ONE;
            if (set_en) cur_pa_d = set_pa;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (pop) begin
         if (!empty) begin
            cur_pa_d = stack_q[rd_idx];
            depth_d  = depth_q - ONE;
         end else begin
            underflow_d = 1'b1;
         end
      end else if (set_en) begin
         cur_pa_d = set_pa;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_pa_q    <= '0;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         // NOTE: the stack storage is cleared too, so it must live in flops rather than a RAM macro.
         for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         cur_pa_q    <= cur_pa_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         if (stack_we) stack_q[wr_idx] <= cur_pa_q;
      end
   end

   always_comb begin
      reg_addr = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         reg_addr[i*ADDR_W +: ADDR_W] = {cur_pa_q, lower_reg_addr[i*LOW_W +: LOW_W]};
   end

   assign cur_pa    = cur_pa_q;
   assign depth     = depth_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_regdecode_stack.sv
// Bench for regdecode_stack: directed steps followed by random traffic, all
// compared against a queue-based stack model of the bank pointer.
module tb_regdecode_stack;

   localparam int PA_W        = 2;
   localparam int LOW_W       = 2;
   localparam int NUM_PORTS   = 3;
   localparam int STACK_DEPTH = 4;
   localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);
   localparam int ADDR_W      = PA_W + LOW_W;

   logic                             clk = 1'b0;
   logic                             reset_n;
   logic                             set_en;
   logic [PA_W-1:0]                  set_pa;
   logic                             push;
   logic                             pop;
   logic                             clr_flags;
   logic [NUM_PORTS*LOW_W-1:0]       lower_reg_addr;
   logic [NUM_PORTS*ADDR_W-1:0]      reg_addr;
   logic [PA_W-1:0]                  cur_pa;
   logic [DEPTH_W-1:0]               depth;
   logic                             overflow;
   logic                             underflow;

   int tests = 0;
   int fails = 0;

   // Reference model: current bank, saved banks as a queue, sticky flags.
   int m_cur;
   int m_stack[$];
   bit m_ovf;
   bit m_unf;

   regdecode_stack #(
      .PA_W(PA_W), .LOW_W(LOW_W), .NUM_PORTS(NUM_PORTS),
      .STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .set_en(set_en), .set_pa(set_pa),
      .push(push), .pop(pop), .clr_flags(clr_flags),
      .lower_reg_addr(lower_reg_addr), .reg_addr(reg_addr),
      .cur_pa(cur_pa), .depth(depth), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_PORTS*ADDR_W-1:0] model_addr();
      logic [NUM_PORTS*ADDR_W-1:0] a;
      logic [PA_W-1:0]             pa;
      pa = PA_W'(m_cur);
      for (int i = 0; i < NUM_PORTS; i++)
         a[i*ADDR_W +: ADDR_W] = {pa, lower_reg_addr[i*LOW_W +: LOW_W]};
      return a;
   endfunction

   task automatic model_edge();
      bit ovf_n, unf_n;
      if (!reset_n) begin
         m_cur = 0;
         m_stack.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         ovf_n = m_ovf && !clr_flags;
         unf_n = m_unf && !clr_flags;
         if (push && pop) begin
            if (set_en) m_cur = int'(set_pa);
         end else if (push) begin
            if (m_stack.size() < STACK_DEPTH) begin
               m_stack.push_back(m_cur);
               if (set_en) m_cur = int'(set_pa);
            end else ovf_n = 1;
         end else if (pop) begin
            if (m_stack.size() > 0) m_cur = m_stack.pop_back();
            else unf_n = 1;
         end else if (set_en) begin
            m_cur = int'(set_pa);
         end
         m_ovf = ovf_n;
         m_unf = unf_n;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".cur_pa"},    32'(cur_pa),    32'(m_cur));
      check({tag, ".depth"},     32'(depth),     32'(m_stack.size()));
      check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
      check({tag, ".reg_addr"},  32'(reg_addr),  32'(model_addr()));
   endtask

   // Apply the current inputs across one rising edge and compare afterwards.
   task automatic cyc(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic rn, input logic se, input logic [PA_W-1:0] sp,
                        input logic pu, input logic po, input logic cf);
      reset_n   = rn;
      set_en    = se;
      set_pa    = sp;
      push      = pu;
      pop       = po;
      clr_flags = cf;
   endtask

   initial begin
      lower_reg_addr = '0;
      drive(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);

      // Reset dominates push and set_en.
      cyc("reset1");
      cyc("reset2");
      lower_reg_addr = 6'b00_00_11;
      #1;
      check("reset.port0", 32'(reg_addr[ADDR_W-1:0]), 32'h3);

      // Set and decode.
      drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      cyc("set2");
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      lower_reg_addr = {2'd3, 2'd2, 2'd1};
      #1;
      check("decode.ports", 32'(reg_addr), 32'({4'b1011, 4'b1010, 4'b1001}));
      check("decode.cur_pa", 32'(cur_pa), 32'h2);

      // Call / return.
      drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      cyc("set1");
      drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      cyc("call");
      check("call.cur_pa", 32'(cur_pa), 32'h3);
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      cyc("return");
      check("return.cur_pa", 32'(cur_pa), 32'h1);
      check("return.depth", 32'(depth), 32'h0);

      // Overflow: fill from bank 0, then one push too many.
      drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      cyc("set0");
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 2'((i + 1) % 4), 1'b1, 1'b0, 1'b0);
         cyc("fill");
      end
      drive(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      cyc("overflow");
      check("overflow.flag", 32'(overflow), 32'h1);
      check("overflow.depth", 32'(depth), 32'h4);
      check("overflow.cur_pa", 32'(cur_pa), 32'h0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
         cyc("drain");
         check("drain.order", 32'(cur_pa), 32'(3 - i));
      end

      // Underflow and clearing.
      drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      cyc("underflow");
      check("underflow.flag", 32'(underflow), 32'h1);
      check("underflow.cur_pa", 32'(cur_pa), 32'h0);
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      cyc("clear");
      check("clear.flags", 32'({overflow, underflow}), 32'h0);
      drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      cyc("error_beats_clear");
      check("error_beats_clear.flag", 32'(underflow), 32'h1);

      // Simultaneous push+pop at depth 2, then reset during a push.
      drive(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      cyc("push_a");
      drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      cyc("push_b");
      drive(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
      cyc("push_pop");
      check("push_pop.depth", 32'(depth), 32'h2);
      check("push_pop.cur_pa", 32'(cur_pa), 32'h2);
      drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      cyc("reset_push");
      check("reset_push.depth", 32'(depth), 32'h0);

      // Random traffic; lower addresses also change between edges.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 7) == 0));
         cyc("rand");
         lower_reg_addr = 6'($urandom);
         #1;
         check("rand.comb_addr", 32'(reg_addr), 32'(model_addr()));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
